// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-detects peripheral interrupt lines, keeps them pending,
// applies a per-line mask and presents the lowest-index candidate to the
// interrupt controller. It tracks the taken line until the handler returns,
// then clears it and sends a one-hot acknowledge back to the peripheral.
//
// Handshake: irq_req_o is only driven in IDLE. The controller accepts by
// raising irq_taken_i while irq_req_o is high; the pair is sampled on the
// rising edge (taken without req is ignored). Completion is signalled by
// irq_ret_i, honoured only in SERVICE. The acknowledge irq_ret_o is a
// one-cycle one-hot pulse in the RETIRE cycle. No output depends
// combinationally on irq_taken_i or irq_ret_i.
module irq_arbiter #(
  parameter int N_IRQ = 16,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_lines_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             irq_taken_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_cause_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    RETIRE  = 2'd2
  } state_e;

  localparam logic [31:0]      CAUSE_BASE = 32'h1000_0010;
  localparam logic [N_IRQ-1:0] ONE_HOT_0  = N_IRQ'(1);

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  active_q, active_d;

  logic [N_IRQ-1:0] irq_event;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  win_id;

  assign irq_event = irq_lines_i & ~prev_q;
  assign cand      = pending_q & irq_mask_i;

  // Fixed priority: lowest candidate index wins.
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  // FSM next state, retire clear and all request/ack outputs.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    clr       = '0;
    irq_req_o = 1'b0;
    irq_ret_o = '0;
    irq_id_o  = active_q;
    unique case (state_q)
      IDLE: begin
        irq_req_o = |cand;
        irq_id_o  = win_id;
        if (irq_taken_i && (|cand)) begin
          active_d = win_id;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_ret_i) begin
          clr     = ONE_HOT_0 << active_q;
          state_d = RETIRE;
        end
      end
      RETIRE: begin
        irq_ret_o = ONE_HOT_0 << active_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event on the same edge as a retire keeps the line pending.
  assign pending_d = (pending_q & ~clr) | irq_event;

  // State, pending, edge-detect history and active line registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= irq_lines_i;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign irq_cause_o = CAUSE_BASE + 32'(irq_id_o);
  assign pending_o   = pending_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with hand-computed expectations.
module tb_irq_arbiter;

  localparam int N_IRQ = 16;
  localparam int ID_W  = 4;

  logic             clk;
  logic             rst;
  logic [N_IRQ-1:0] lines;
  logic [N_IRQ-1:0] mask;
  logic             taken;
  logic             ret;
  logic             req;
  logic [31:0]      cause;
  logic [ID_W-1:0]  id;
  logic [N_IRQ-1:0] ret_ack;
  logic [N_IRQ-1:0] pending;
  logic [1:0]       state;

  int checks   = 0;
  int failures = 0;
  int svc_cnt;

  irq_arbiter #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_lines_i (lines),
    .irq_mask_i  (mask),
    .irq_taken_i (taken),
    .irq_ret_i   (ret),
    .irq_req_o   (req),
    .irq_cause_o (cause),
    .irq_id_o    (id),
    .irq_ret_o   (ret_ack),
    .pending_o   (pending),
    .dbg_state_o (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: take the current request, then return it; leaves the DUT in RETIRE.
  task automatic take_and_ret();
    taken = 1'b1; tick(); taken = 1'b0;
    ret   = 1'b1; tick(); ret   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lines = '0; mask = '1; taken = 1'b0; ret = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req",     32'(req), 32'd0);
    check("rst_ret",     32'(ret_ack), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_id",      32'(id), 32'd0);
    check("rst_cause",   cause, 32'h1000_0010);

    // Single line 5
    lines = 16'h0020; tick();
    check("l5_pending", 32'(pending), 32'h0020);
    check("l5_req",     32'(req), 32'd1);
    check("l5_id",      32'(id), 32'd5);
    check("l5_cause",   cause, 32'h1000_0015);
    taken = 1'b1; tick(); taken = 1'b0;
    check("l5_taken_req", 32'(req), 32'd0);
    check("l5_svc_id",    32'(id), 32'd5);
    check("l5_svc_state", 32'(state), 32'd1);
    tick();
    check("l5_svc_noack", 32'(ret_ack), 32'd0);
    ret = 1'b1; tick(); ret = 1'b0;
    check("l5_ack",        32'(ret_ack), 32'h0020);
    check("l5_ack_pend",   32'(pending), 32'd0);
    check("l5_ack_req",    32'(req), 32'd0);
    tick();
    check("l5_ack_once",   32'(ret_ack), 32'd0);
    check("l5_level_noreq", 32'(req), 32'd0);
    lines = '0; tick();

    // Priority: lines 7 and 2 together
    lines = 16'h0084; tick();
    check("pri_id",      32'(id), 32'd2);
    check("pri_cause",   cause, 32'h1000_0012);
    check("pri_pending", 32'(pending), 32'h0084);
    take_and_ret();
    check("pri_ack2",    32'(ret_ack), 32'h0004);
    check("pri_pend7",   32'(pending), 32'h0080);
    check("pri_ret_req", 32'(req), 32'd0);
    tick();
    check("pri_req7",    32'(req), 32'd1);
    check("pri_id7",     32'(id), 32'd7);
    check("pri_cause7",  cause, 32'h1000_0017);
    take_and_ret();
    check("pri_ack7",    32'(ret_ack), 32'h0080);
    tick(); lines = '0; tick();

    // Mask holds a pending line back
    mask = 16'hFFEF; lines = 16'h0010; tick();
    check("msk_req",     32'(req), 32'd0);
    check("msk_pending", 32'(pending), 32'h0010);
    taken = 1'b1; tick(); taken = 1'b0;
    check("msk_taken_ign", 32'(state), 32'd0);
    check("msk_req2",    32'(req), 32'd0);
    mask = '1; #1;
    check("msk_on_req",  32'(req), 32'd1);
    check("msk_on_id",   32'(id), 32'd4);
    take_and_ret();
    check("msk_ack",     32'(ret_ack), 32'h0010);
    tick(); lines = '0; tick();

    // No preemption while servicing line 6, then set-wins on line 6
    lines = 16'h0040; tick();
    taken = 1'b1; tick(); taken = 1'b0;
    lines = 16'h0041; tick();
    check("np_req",     32'(req), 32'd0);
    check("np_id",      32'(id), 32'd6);
    check("np_pending", 32'(pending), 32'h0041);
    lines = 16'h0001; tick();
    check("np_req2",    32'(req), 32'd0);
    ret = 1'b1; lines = 16'h0041; tick(); ret = 1'b0;
    check("sw_ack",     32'(ret_ack), 32'h0040);
    check("sw_pending", 32'(pending), 32'h0041);
    check("sw_req",     32'(req), 32'd0);
    tick();
    check("np_req0",    32'(req), 32'd1);
    check("np_id0",     32'(id), 32'd0);
    take_and_ret();
    check("np_ack0",    32'(ret_ack), 32'h0001);
    check("np_pend6",   32'(pending), 32'h0040);
    tick();
    check("sw_req6",    32'(req), 32'd1);
    check("sw_id6",     32'(id), 32'd6);
    take_and_ret();
    check("sw_ack6",    32'(ret_ack), 32'h0040);
    tick(); lines = '0; tick();
    check("np_clear",   32'(pending), 32'd0);

    // Level hold on line 1: exactly one service
    svc_cnt = 0;
    lines = 16'h0002;
    for (int i = 0; i < 20; i++) begin
      if (req) taken = 1'b1;
      else if (state == 2'd1) ret = 1'b1;
      tick();
      taken = 1'b0; ret = 1'b0;
      if (ret_ack[1]) svc_cnt++;
    end
    check("lvl_services", 32'(svc_cnt), 32'd1);
    check("lvl_pending",  32'(pending), 32'd0);
    lines = '0; tick();

    // Spurious handshakes in IDLE with nothing pending
    ret = 1'b1; taken = 1'b1; tick(); ret = 1'b0; taken = 1'b0;
    check("sp_state",   32'(state), 32'd0);
    check("sp_req",     32'(req), 32'd0);
    check("sp_ack",     32'(ret_ack), 32'd0);
    tick();
    check("sp_ack2",    32'(ret_ack), 32'd0);

    // Reset in the middle of servicing line 3
    lines = 16'h0008; tick();
    check("rs_id",      32'(id), 32'd3);
    taken = 1'b1; tick(); taken = 1'b0;
    check("rs_state",   32'(state), 32'd1);
    rst = 1'b1; lines = '0; tick(); rst = 1'b0;
    check("rs_pending", 32'(pending), 32'd0);
    check("rs_req",     32'(req), 32'd0);
    check("rs_cause",   cause, 32'h1000_0010);
    check("rs_id0",     32'(id), 32'd0);
    check("rs_state0",  32'(state), 32'd0);
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1; tick(); ret = 1'b0;
      check("rs_no_ack", 32'(ret_ack), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Peripheral interrupt arbiter sitting directly upstream of the core's interrupt controller. It edge-detects up to N_IRQ peripheral request lines, holds each event as a pending bit, applies a per-line mask, and selects the highest-priority pending line. It presents a single request with a matching cause code to the interrupt controller. It tracks the taken interrupt until the controller signals return, then clears that line and sends a one-hot acknowledge pulse back to the originating peripheral.

## Interface

- N_IRQ, default 16, number of peripheral request lines (2..32)
- ID_W, default $clog2(N_IRQ), width of line index
- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- irq_lines_i  input  N_IRQ  raw peripheral request lines; event = rising edge
- irq_mask_i  input  N_IRQ  per-line enable; 1 = line may be requested
- irq_taken_i  input  1  controller accepted the request (controller's irq_o)
- irq_ret_i  input  1  controller finished the handler (controller's irq_ret_o, mret retired)
- irq_req_o  output  1  request to controller (controller's irq_req_i)
- irq_cause_o  output  32  cause for selected/active line: 32'h1000_0010 + index
- irq_id_o  output  ID_W  selected/active line index
- irq_ret_o  output  N_IRQ  one-hot, one-cycle acknowledge to serviced peripheral
- pending_o  output  N_IRQ  pending register, for debug/CSR readback

## Operation

- Edge detect: prev register holds last sample of irq_lines_i; event[i] = irq_lines_i[i] & ~prev[i]. prev resets to 0, so a line already high after reset counts as an event on the first cycle.
- Pending: pending[i] is set by event[i] and cleared by retire of line i. If set and clear coincide on the same line, set wins; the new event is not lost.
- Candidates are pending & irq_mask_i. Priority is fixed: lowest index wins.
- Masked pending bits are retained and become requestable when the mask bit is set.
- FSM states: IDLE, SERVICE, RETIRE.
  - IDLE: irq_req_o = |(pending & mask). irq_id_o and irq_cause_o follow the combinational winner and may change each cycle. If irq_taken_i & irq_req_o, latch the winner into active_id and go to SERVICE. irq_taken_i with irq_req_o low is ignored.
  - SERVICE: irq_req_o = 0. irq_id_o and irq_cause_o show active_id. Mask changes and new events do not preempt. On irq_ret_i, clear pending[active_id] and go to RETIRE.
  - RETIRE: irq_ret_o = one-hot(active_id). irq_req_o = 0. Go to IDLE unconditionally.
- irq_ret_i in IDLE or RETIRE is ignored.
- Width rule: irq_cause_o = 32'h1000_0010 + zero-extended index; index 0 yields 32'h1000_0010.
- Reset (rst_i high at an edge), from any state including mid-service:
  - state = IDLE, pending = 0, prev = 0, active_id = 0.
  - Resulting outputs: irq_req_o = 0, irq_ret_o = 0, pending_o = 0, irq_id_o = 0, irq_cause_o = 32'h1000_0010.
  - No irq_ret_o pulse is emitted for an aborted service.

## Timing

- Line rises before edge k, so the event is sampled at edge k. pending_o and irq_req_o are high in the cycle after edge k: 1-cycle latency.
- irq_taken_i high at edge m: SERVICE from m. irq_req_o is low in the cycle after m.
- irq_ret_i high at edge r in SERVICE:
  - irq_ret_o pulses for exactly the cycle after r (RETIRE).
  - The pending bit is low in that same cycle.
  - IDLE from edge r+1, so the next request can assert in the cycle after r+1.
- Minimum spacing between two serviced interrupts: taken → ret → 1 RETIRE cycle → IDLE.
- A level held high on a line generates exactly one event; a new event needs the line to fall and rise again.
- All outputs are functions of registered state plus irq_mask_i, pending and active_id. There are no combinational paths from irq_taken_i or irq_ret_i to outputs.

## Test plan

- Reset mid-SERVICE: take line 3, assert rst_i one cycle → pending_o = 0, irq_req_o = 0, irq_ret_o never pulses, irq_cause_o = 32'h1000_0010.
- Single line: raise line 5 → irq_req_o high next cycle, irq_id_o = 5, irq_cause_o = 32'h1000_0015. Then irq_taken_i → irq_req_o low. Then irq_ret_i → irq_ret_o = 16'h0020 for one cycle, pending_o[5] = 0.
- Priority: raise lines 7 and 2 together → id 2 serviced first (cause 32'h1000_0012). After RETIRE, id 7 requested (cause 32'h1000_0017).
- Mask: raise line 4 with mask[4] = 0 → irq_req_o stays 0 and pending_o[4] = 1. Set mask[4] → irq_req_o = 1 with id 4.
- No preemption / set-wins:
  - Serving line 6, raise line 0 → no request until RETIRE ends, then id 0.
  - Re-raise line 6 in the irq_ret_i cycle → pending_o[6] stays 1 and line 6 is requested again.
- Level hold and spurious handshakes: hold line 1 high for 20 cycles → one service only. irq_ret_i/irq_taken_i pulsed in IDLE with nothing pending → no state change, irq_ret_o = 0.
